serial_word_receiver: RTL and testbench

Serial-in, parallel-out word receiver for the register-file shift datapath. It collects a framed serial bit stream, one bit per `bit_valid` cycle, into a `WIDTH`-bit word. Each bit enters either MSB-first (left shift) or LSB-first (right shift). The completed word is presented on a valid/ready output port backed by a one-word holding buffer. The block sits at the far end of the shift-register transmitters and turns their serial output back into parallel words for downstream logic.

---
 rtl/serial_word_receiver.sv | 181 ++++++++++++++++++
 tb/tb_serial_word_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Collects a framed serial bit stream into a WIDTH-bit word. Each frame is
//   shifted either MSB-first (left shift) or LSB-first (right shift). The
//   direction is latched on the first bit of the frame. The finished word is
//   handed to a one-word holding buffer with a valid/ready output port.
//
//   Optional feature macro: SERIAL_WORD_RECEIVER_PARITY_EN
//     Defined   : each frame carries WIDTH data bits plus one even-parity bit.
//                 A bad word is dropped and parity_err is set (sticky).
//     Undefined : frames are WIDTH bits; parity_err is tied to 0.
//
//   Handshake: word_valid high means word_out holds an undelivered word.
//   The consumer takes it on any rising edge where word_valid && word_ready.
//   While word_valid is high and the word is not taken, word_out is stable.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   bit_in       : serial data bit, sampled when bit_valid is high
//   bit_valid    : qualifies bit_in on this edge
//   msb_first    : 1 = left shift, 0 = right shift (latched per frame)
//   word_out     : holding-buffer contents
//   word_valid   : holding buffer full
//   word_ready   : consumer accepts the word
//   bit_count    : bits collected in the current frame
//   overrun      : sticky, a completed word was dropped (buffer full)
//   parity_err   : sticky, a frame failed its parity check
//   state_dbg    : current FSM state (0 = IDLE, 1 = SHIFT)
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic                       msb_first,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun,
    output logic                       parity_err,
    output logic                       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    // The frame completes on the parity bit, which follows the data bits.
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    // Frame completion is handled on the edge that samples the final bit,
    // so the FSM never rests in a separate completion state.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              dir_q, dir_d;
    logic [CW-1:0]     cnt_d;
    logic [WIDTH-1:0]  word_d;
    logic              valid_d;
    logic              overrun_d;
    logic              dir;
    logic              last_bit;
    logic              accept;
    logic              good;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  assembled;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    logic              perr_d;
`endif

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        dir_d     = dir_q;
        cnt_d     = bit_count;
        word_d    = word_out;
        valid_d   = word_valid;
        overrun_d = overrun;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        perr_d    = parity_err;
`endif

        // The first bit of a frame uses the live msb_first; later bits use
        // the latched direction so mid-frame changes are ignored.
        dir      = (state_q == IDLE) ? msb_first : dir_q;
        shifted  = dir ? {sr_q[WIDTH-2:0], bit_in} : {bit_in, sr_q[WIDTH-1:1]};
        last_bit = bit_valid && (bit_count == CW'(LAST));
        accept   = word_valid && word_ready;

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        // Data bits are already in sr when the parity bit arrives.
        assembled = sr_q;
        good      = ~((^sr_q) ^ bit_in);
`else
        assembled = shifted;
        good      = 1'b1;
`endif

        if (accept) begin
            valid_d = 1'b0;
        end

        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    dir_d   = msb_first;
                    sr_d    = shifted;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    // Only data bits enter sr; a parity bit arrives at count WIDTH.
                    if (bit_count < CW'(WIDTH)) begin
                        sr_d = shifted;
                    end
                    if (last_bit) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (good) begin
                            // A buffer drained on this same edge can take the new word.
                            if (!word_valid || word_ready) begin
                                word_d  = assembled;
                                valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                            perr_d = 1'b1;
`endif
                        end
                    end else begin
                        cnt_d = bit_count + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            dir_q      <= 1'b0;
            bit_count  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            dir_q      <= dir_d;
            bit_count  <= cnt_d;
            word_out   <= word_d;
            word_valid <= valid_d;
            overrun    <= overrun_d;
        end
    end

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver
//   Directed bench for serial_word_receiver at WIDTH=4. Delivered words are
//   checked by a monitor against an expected queue; bit_count, flags and
//   buffer state are checked directly after each driving edge.
module tb_serial_word_receiver;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic             clk;
    logic             reset;
    logic             bit_in;
    logic             bit_valid;
    logic             msb_first;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overrun;
    logic             parity_err;
    logic             state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .msb_first (msb_first),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .bit_count (bit_count),
        .overrun   (overrun),
        .parity_err(parity_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic send_par(input logic [3:0] seq);
        if (P == 1) send_bit(^seq);
    endtask

    // seq[3] is sent first. When set_ready_last is set, word_ready is
    // raised just before the bit that completes the frame.
    task automatic send_frame(input logic [3:0] seq, input bit set_ready_last);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0 && P == 0 && set_ready_last) word_ready = 1'b1;
            send_bit(seq[i]);
        end
        if (P == 1) begin
            if (set_ready_last) word_ready = 1'b1;
            send_bit(^seq);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Sampled on the falling edge: a word seen with valid && ready here is
    // taken by the consumer at the next rising edge.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(word_out), 32'hffff_ffff);
            end else begin
                check("sb_word", 32'(word_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] seq;
        reset      = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        msb_first  = 1'b1;
        word_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_word_out", 32'(word_out), 0);
        check("rst_word_valid", 32'(word_valid), 0);
        check("rst_bit_count", 32'(bit_count), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        check("rst_state", 32'(state_dbg), 0);

        // Left shift 1,0,1,1 -> 1011; bit_count 1,2,3,0
        word_ready = 1'b1;
        msb_first  = 1'b1;
        seq        = 4'b1011;
        exp_q.push_back(4'b1011);
        for (int i = 3; i >= 0; i--) begin
            send_bit(seq[i]);
            check("left_bit_count", 32'(bit_count), (i == 0) ? ((P == 1) ? 4 : 0) : 32'(4 - i));
        end
        send_par(seq);
        check("left_count_wrap", 32'(bit_count), 0);
        check("left_valid", 32'(word_valid), 1);
        check("left_word", 32'(word_out), 32'h b);
        step();
        check("left_drained", 32'(word_valid), 0);

        // Right shift with a 3-cycle gap and a msb_first flip in the gap -> 1101
        msb_first = 1'b0;
        exp_q.push_back(4'b1101);
        send_bit(1'b1);
        send_bit(1'b0);
        msb_first = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            check("gap_bit_count", 32'(bit_count), 2);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        send_par(4'b1011);
        check("right_valid", 32'(word_valid), 1);
        check("right_word", 32'(word_out), 32'h d);
        step();

        // Overrun: consumer stalled, 1011 then 0110
        word_ready = 1'b0;
        msb_first  = 1'b1;
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0);
        check("ovr_first_no_flag", 32'(overrun), 0);
        send_frame(4'b0110, 1'b0);
        check("ovr_word_kept", 32'(word_out), 32'h b);
        check("ovr_valid", 32'(word_valid), 1);
        check("ovr_flag", 32'(overrun), 1);
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        check("ovr_drained", 32'(word_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // Back-to-back: acceptance and new completion on the same edge
        do_reset();
        check("b2b_rst_overrun", 32'(overrun), 0);
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b0110);
        send_frame(4'b1011, 1'b0);
        send_frame(4'b0110, 1'b1);
        check("b2b_valid_held", 32'(word_valid), 1);
        check("b2b_new_word", 32'(word_out), 32'h6);
        check("b2b_no_overrun", 32'(overrun), 0);
        step();
        check("b2b_drained", 32'(word_valid), 0);

        // Reset mid-frame with a buffered word present
        word_ready = 1'b0;
        exp_q.push_back(4'b1001);
        word_ready = 1'b1;
        send_frame(4'b1001, 1'b0);
        word_ready = 1'b0;
        exp_q.delete();
        send_frame(4'b0101, 1'b0);
        check("mid_buffer_full", 32'(word_valid), 1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("mid_partial_count", 32'(bit_count), 2);
        do_reset();
        check("mid_rst_count", 32'(bit_count), 0);
        check("mid_rst_valid", 32'(word_valid), 0);
        check("mid_rst_state", 32'(state_dbg), 0);
        word_ready = 1'b1;
        exp_q.push_back(4'b0011);
        send_frame(4'b0011, 1'b0);
        check("mid_next_word", 32'(word_out), 32'h3);
        step();

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        // Good parity delivers; bad parity drops and sets parity_err
        do_reset();
        word_ready = 1'b1;
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0);
        step();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("par_count_w", 32'(bit_count), 4);
        send_bit(1'b0);
        check("par_err", 32'(parity_err), 1);
        check("par_no_delivery", 32'(word_valid), 0);
        check("par_no_overrun", 32'(overrun), 0);
        step();
`endif

        step();
        check("sb_queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
